block_memory: RTL and testbench

Parametrised, block-organised scratch memory for the coprocessor. It holds `size` cells of `cell_width` bits and moves `blocks` consecutive cells per access. It adds several things a flat block memory lacks: per-cell write masking, address wrap-around, a read-valid handshake, a ready/busy indication, and a hardware clear engine that zeroes the array after reset or on request. Cells 0 (config) and 1 (status) are exposed continuously to the coprocessor control path.

---
 rtl/block_memory.sv | 156 +++++++++++++++
 tb/tb_block_memory.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/block_memory.sv
// Block-organised scratch memory: multi-cell masked accesses with wrap-around, a
// one-cycle read-valid pulse and a clear engine that zeroes the array after reset or on request.
module block_memory #(
    parameter int size       = 1024,
    parameter int log_size   = 10,
    parameter int blocks     = 4,
    parameter int cell_width = 32,
    localparam int width     = blocks * cell_width
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic [log_size-1:0]   in_address,
    input  logic [width-1:0]      in_data,
    input  logic [blocks-1:0]     in_mask,
    input  logic                  in_write_en,
    input  logic                  in_read_en,
    input  logic                  in_clear_en,
    input  logic [cell_width-1:0] in_status,
    input  logic                  in_write_status_en,
    output logic [width-1:0]      out_data,
    output logic                  out_valid,
    output logic                  out_ready,
    output logic [cell_width-1:0] out_status,
    output logic [cell_width-1:0] out_config
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    localparam logic [log_size-1:0] LAST_BASE  = log_size'(size - blocks);
    localparam logic [log_size-1:0] GROUP_STEP = log_size'(blocks);

    state_t                 state_r;
    logic [log_size-1:0]    ptr_r;      // base cell of the group being cleared
    logic [width-1:0]       data_r;
    logic                   valid_r;
    logic                   ready_r;
    logic [cell_width-1:0]  config_r;
    logic [cell_width-1:0]  status_r;
    logic [cell_width-1:0]  mem_r [size];   // cells 0 and 1 live in config_r/status_r

    logic [log_size-1:0]    acc_idx_s [blocks];
    logic [log_size-1:0]    clr_idx_s [blocks];
    logic [width-1:0]       rd_data_s;
    logic                   idle_s;
    logic                   wr_s;
    logic                   rd_s;

    assign idle_s = (state_r == ST_IDLE);
    assign wr_s   = idle_s & in_write_en;
    assign rd_s   = idle_s & in_read_en;

    // Per-cell access and clear indices; address arithmetic wraps at size.
    always_comb begin
        for (int i = 0; i < blocks; i++) begin
            acc_idx_s[i] = in_address + log_size'(i);
            clr_idx_s[i] = ptr_r + log_size'(i);
        end
    end

    // Gather read data, steering cells 0 and 1 from their dedicated registers.
    always_comb begin
        rd_data_s = '0;
        for (int i = 0; i < blocks; i++) begin
            if (acc_idx_s[i] == log_size'(0)) begin
                rd_data_s[i*cell_width +: cell_width] = config_r;
            end else if (acc_idx_s[i] == log_size'(1)) begin
                rd_data_s[i*cell_width +: cell_width] = status_r;
            end else begin
                rd_data_s[i*cell_width +: cell_width] = mem_r[acc_idx_s[i]];
            end
        end
    end

    // Bulk array storage: zeroed by the clear engine, never by reset.
    always_ff @(posedge in_clk) begin
        for (int i = 0; i < blocks; i++) begin
            if (state_r == ST_INIT) begin
                mem_r[clr_idx_s[i]] <= '0;
            end else if (wr_s && in_mask[i]) begin
                mem_r[acc_idx_s[i]] <= in_data[i*cell_width +: cell_width];
            end
        end
    end

    // Config and status cells; a status write is assigned last so it overrides a same-edge block write or clear.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            config_r <= '0;
            status_r <= '0;
        end else begin
            for (int i = 0; i < blocks; i++) begin
                if (state_r == ST_INIT) begin
                    if (clr_idx_s[i] == log_size'(0)) config_r <= '0;
                    if (clr_idx_s[i] == log_size'(1)) status_r <= '0;
                end else if (wr_s && in_mask[i]) begin
                    if (acc_idx_s[i] == log_size'(0)) config_r <= in_data[i*cell_width +: cell_width];
                    if (acc_idx_s[i] == log_size'(1)) status_r <= in_data[i*cell_width +: cell_width];
                end
            end
            if (in_write_status_en) begin
                status_r <= in_status;
            end
        end
    end

    // Control FSM: clear sequencing, read response and ready indication.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_r <= ST_INIT;
            ptr_r   <= '0;
            data_r  <= '0;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    valid_r <= 1'b0;
                    if (ptr_r == LAST_BASE) begin
                        state_r <= ST_IDLE;
                        ptr_r   <= '0;
                        ready_r <= 1'b1;
                    end else begin
                        ptr_r <= ptr_r + GROUP_STEP;
                    end
                end
                ST_IDLE: begin
                    valid_r <= rd_s;
                    if (rd_s) begin
                        data_r <= rd_data_s;
                    end
                    if (in_clear_en) begin
                        state_r <= ST_INIT;
                        ptr_r   <= '0;
                        ready_r <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    ptr_r   <= '0;
                    valid_r <= 1'b0;
                    ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign out_data   = data_r;
    assign out_valid  = valid_r;
    assign out_ready  = ready_r;
    assign out_status = status_r;
    assign out_config = config_r;

endmodule

// File: tb/tb_block_memory.sv
// Scoreboard bench for block_memory (size=16, blocks=4): a cell-array model predicts reads,
// which a separate negedge monitor checks against out_valid/out_data.
module tb_block_memory;

    localparam int SZ = 16;
    localparam int BL = 4;
    localparam int CW = 32;
    localparam int W  = BL * CW;

    logic           clk;
    logic           rst_n;
    logic [3:0]     address;
    logic [W-1:0]   wdata;
    logic [BL-1:0]  mask;
    logic           write_en;
    logic           read_en;
    logic           clear_en;
    logic [CW-1:0]  status_in;
    logic           write_status_en;
    logic [W-1:0]   rdata;
    logic           valid;
    logic           ready;
    logic [CW-1:0]  status_out;
    logic [CW-1:0]  config_out;

    typedef struct {
        logic [W-1:0] d;
        int           due;
    } exp_t;

    exp_t         sb_q[$];
    logic [CW-1:0] mdl[SZ];
    int           cyc;
    int           n_checks;
    int           n_fail;

    block_memory #(.size(SZ), .log_size(4), .blocks(BL), .cell_width(CW)) dut (
        .in_clk(clk), .in_reset(rst_n), .in_address(address), .in_data(wdata),
        .in_mask(mask), .in_write_en(write_en), .in_read_en(read_en),
        .in_clear_en(clear_en), .in_status(status_in),
        .in_write_status_en(write_status_en), .out_data(rdata), .out_valid(valid),
        .out_ready(ready), .out_status(status_out), .out_config(config_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: out_valid must pulse exactly on the cycle a read is due, with model data.
    always @(negedge clk) begin
        logic exp_v;
        exp_v = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        chk("read_valid", {127'd0, valid}, {127'd0, exp_v});
        if (exp_v) begin
            chk("read_data", rdata, sb_q[0].d);
            void'(sb_q.pop_front());
        end
    end

    function automatic logic [W-1:0] model_read(input logic [3:0] a);
        logic [W-1:0] r;
        for (int i = 0; i < BL; i++) r[i*CW +: CW] = mdl[(int'(a) + i) % SZ];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One accepted cycle in IDLE; the model is updated from the architectural rules.
    task automatic do_cycle(input bit rd, input bit wr, input logic [3:0] a, input logic [W-1:0] d,
                            input logic [3:0] m, input bit sten, input logic [CW-1:0] st, input bit clr);
        exp_t e;
        chk("ready_idle", {127'd0, ready}, {127'd0, 1'b1});
        address = a; wdata = d; mask = m; read_en = rd; write_en = wr;
        write_status_en = sten; status_in = st; clear_en = clr;
        if (rd) begin
            e.d = model_read(a);
            e.due = cyc + 1;
            sb_q.push_back(e);
        end
        if (wr) for (int i = 0; i < BL; i++) if (m[i]) mdl[(int'(a) + i) % SZ] = d[i*CW +: CW];
        if (sten) mdl[1] = st;
        tick();
        read_en = 1'b0; write_en = 1'b0; write_status_en = 1'b0; clear_en = 1'b0;
        if (!clr) begin
            chk("config_view", {96'd0, config_out}, {96'd0, mdl[0]});
            chk("status_view", {96'd0, status_out}, {96'd0, mdl[1]});
        end
    endtask

    // Ready must stay low for exactly SZ/BL edges of clearing, then rise.
    task automatic clear_wait();
        for (int k = 0; k < SZ / BL; k++) begin
            chk("ready_low", {127'd0, ready}, {127'd0, 1'b0});
            tick();
        end
        chk("ready_rise", {127'd0, ready}, {127'd0, 1'b1});
        for (int c = 0; c < SZ; c++) mdl[c] = '0;
        chk("config_clr", {96'd0, config_out}, {96'd0, mdl[0]});
        chk("status_clr", {96'd0, status_out}, {96'd0, mdl[1]});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_data", rdata, '0);
        chk("rst_valid", {127'd0, valid}, {127'd0, 1'b0});
        chk("rst_ready", {127'd0, ready}, {127'd0, 1'b0});
        chk("rst_config", {96'd0, config_out}, {96'd0, 32'd0});
        chk("rst_status", {96'd0, status_out}, {96'd0, 32'd0});
        #1;
        rst_n = 1'b1;
        clear_wait();
    endtask

    task automatic read_all();
        for (int g = 0; g < SZ / BL; g++) do_cycle(1'b1, 1'b0, 4'(g * BL), '0, 4'h0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic fill_random();
        for (int g = 0; g < SZ / BL; g++)
            do_cycle(1'b0, 1'b1, 4'(g * BL), {$urandom, $urandom, $urandom, $urandom}, 4'hF, 1'b0, 32'd0, 1'b0);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; address = '0; wdata = '0; mask = '0; write_en = 1'b0; read_en = 1'b0;
        clear_en = 1'b0; status_in = '0; write_status_en = 1'b0;
        for (int c = 0; c < SZ; c++) mdl[c] = '0;
        tick();
        do_reset();
        read_all();

        // Masked write
        do_cycle(1'b0, 1'b1, 4'd4, {32'd44, 32'd33, 32'd22, 32'd11}, 4'b0101, 1'b0, 32'd0, 1'b0);
        do_cycle(1'b1, 1'b0, 4'd4, '0, 4'h0, 1'b0, 32'd0, 1'b0);
        tick();
        chk("masked_fixed", rdata, {32'd0, 32'd33, 32'd0, 32'd11});

        // Wrap-around
        do_cycle(1'b0, 1'b1, 4'd14, {32'd4, 32'd3, 32'd2, 32'd1}, 4'hF, 1'b0, 32'd0, 1'b0);
        do_cycle(1'b1, 1'b0, 4'd0, '0, 4'h0, 1'b0, 32'd0, 1'b0);
        tick();
        chk("wrap_fixed", rdata, {32'd0, 32'd0, 32'd4, 32'd3});
        do_cycle(1'b1, 1'b0, 4'd14, '0, 4'h0, 1'b0, 32'd0, 1'b0);

        // Same-cycle read and write: read returns pre-write contents
        do_cycle(1'b0, 1'b1, 4'd8, {32'hA, 32'hB, 32'hC, 32'hD}, 4'hF, 1'b0, 32'd0, 1'b0);
        do_cycle(1'b1, 1'b1, 4'd8, {32'd1, 32'd2, 32'd3, 32'd4}, 4'hF, 1'b0, 32'd0, 1'b0);
        do_cycle(1'b1, 1'b0, 4'd8, '0, 4'h0, 1'b0, 32'd0, 1'b0);

        // Status write beats a block write to cell 1
        do_cycle(1'b0, 1'b1, 4'd0, {32'd0, 32'd0, 32'hAAAA, 32'h1234}, 4'hF, 1'b1, 32'h5555, 1'b0);
        chk("status_prio", {96'd0, status_out}, {96'd0, 32'h5555});
        chk("config_write", {96'd0, config_out}, {96'd0, 32'h1234});

        // Randomized traffic, including back-to-back accesses
        for (int n = 0; n < 200; n++)
            do_cycle(1'($urandom), 1'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom},
                     4'($urandom), ($urandom % 8) == 0, $urandom, 1'b0);

        // Clear request with a same-cycle read (read served first)
        fill_random();
        do_cycle(1'b1, 1'b0, 4'($urandom), '0, 4'h0, 1'b0, 32'd0, 1'b1);
        clear_wait();
        read_all();

        // Reset in the middle of a clear restarts the engine
        fill_random();
        do_cycle(1'b0, 1'b0, 4'd0, '0, 4'h0, 1'b0, 32'd0, 1'b1);
        tick();
        tick();
        chk("mid_clear_ready", {127'd0, ready}, {127'd0, 1'b0});
        do_reset();
        read_all();

        // Drain the scoreboard within a bounded number of cycles
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) tick();
        chk("drain", W'(sb_q.size()), '0);
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
